// File: rtl/dcache_snoop_responder.sv
// Snoop responder for one L1 data cache on the MSI bus: looks up the 2-way frame array,
// forwards an M block as two words under dwait, and downgrades or invalidates the frame.
//
// state  | meaning
// IDLE   | waiting for ccwait; standalone ccinv pulses invalidate a hit line in place
// LOOKUP | snoop latched, cctrans raised if the line was M
// RESP   | holding the response while ccwait is high; decides forward vs. plain update
// XFER0  | word0 presented, waiting for dwait low
// XFER1  | word1 presented, frame update on acceptance
module dcache_snoop_responder #(
   parameter int IDX_W = 3,
   parameter int TAG_W = 26
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 ccwait,
   input  logic                 ccinv,
   input  logic [31:0]          ccsnoopaddr,
   input  logic                 dwait,
   output logic                 cctrans,
   output logic [31:0]          snp_daddr,
   output logic [31:0]          snp_dstore,
   output logic                 snp_active,
   output logic [IDX_W-1:0]     fr_index,
   input  logic [1:0]           fr_valid,
   input  logic [1:0]           fr_dirty,
   input  logic [2*TAG_W-1:0]   fr_tag,
   input  logic [127:0]         fr_data,
   output logic                 upd_en,
   output logic                 upd_way,
   output logic                 upd_valid,
   output logic                 upd_dirty
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_RESP, S_XFER0, S_XFER1
   } state_t;

   state_t             state_q, state_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               inv_q, inv_d;
   logic               way_q, way_d;
   logic               m_q, m_d;
   logic               s_q, s_d;
   logic [63:0]        blk_q, blk_d;
   logic               cctrans_q, cctrans_d;
   logic               snp_active_q, snp_active_d;
   logic [31:0]        snp_daddr_q, snp_daddr_d;
   logic [31:0]        snp_dstore_q, snp_dstore_d;
   logic               upd_en_c;

   logic [TAG_W-1:0]   in_tag;
   logic [IDX_W-1:0]   in_idx;
   logic [1:0]         hit;
   logic               m_in;
   logic [63:0]        blk_in;
   logic               unused_addr_lsb;

   assign in_tag          = ccsnoopaddr[31:IDX_W+3];
   assign in_idx          = ccsnoopaddr[IDX_W+2:3];
   assign unused_addr_lsb = ^ccsnoopaddr[2:0];

   assign fr_index = (state_q == S_IDLE) ? in_idx : idx_q;

   assign hit[0] = fr_valid[0] && (fr_tag[TAG_W-1:0] == in_tag);
   assign hit[1] = fr_valid[1] && (fr_tag[2*TAG_W-1:TAG_W] == in_tag);
   assign m_in   = |(hit & fr_dirty);
   assign blk_in = hit[1] ? fr_data[127:64] : (hit[0] ? fr_data[63:0] : 64'd0);

   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      idx_d        = idx_q;
      inv_d        = inv_q;
      way_d        = way_q;
      m_d          = m_q;
      s_d          = s_q;
      blk_d        = blk_q;
      cctrans_d    = cctrans_q;
      snp_active_d = snp_active_q;
      snp_daddr_d  = snp_daddr_q;
      snp_dstore_d = snp_dstore_q;
      upd_en_c     = 1'b0;
      upd_way      = way_q;
      upd_valid    = 1'b0;
      upd_dirty    = 1'b0;

      case (state_q)
         S_IDLE: begin
            upd_way = hit[1];
            if (ccwait) begin
               tag_d        = in_tag;
               idx_d        = in_idx;
               inv_d        = ccinv;
               way_d        = hit[1];
               m_d          = m_in;
               s_d          = (|hit) && !m_in;
               blk_d        = blk_in;
               cctrans_d    = m_in;
               snp_active_d = 1'b1;
               // word0 goes out early: the controller samples a registered copy
               snp_daddr_d  = {in_tag, in_idx, 3'b000};
               snp_dstore_d = blk_in[31:0];
               state_d      = S_LOOKUP;
            end else if (ccinv && (|hit)) begin
               upd_en_c = 1'b1;
            end
         end
         S_LOOKUP: state_d = S_RESP;
         S_RESP: begin
            if (!ccwait) begin
               cctrans_d = 1'b0;
               if (m_q) begin
                  if (!dwait) begin
                     snp_daddr_d  = {tag_q, idx_q, 3'b100};
                     snp_dstore_d = blk_q[63:32];
                     state_d      = S_XFER1;
                  end else begin
                     state_d = S_XFER0;
                  end
               end else begin
                  upd_en_c     = s_q && inv_q;
                  snp_active_d = 1'b0;
                  snp_daddr_d  = 32'd0;
                  snp_dstore_d = 32'd0;
                  state_d      = S_IDLE;
               end
            end
         end
         S_XFER0: begin
            if (!dwait) begin
               snp_daddr_d  = {tag_q, idx_q, 3'b100};
               snp_dstore_d = blk_q[63:32];
               state_d      = S_XFER1;
            end
         end
         S_XFER1: begin
            if (!dwait) begin
               upd_en_c     = 1'b1;
               upd_valid    = !inv_q;
               snp_active_d = 1'b0;
               snp_daddr_d  = 32'd0;
               snp_dstore_d = 32'd0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         tag_q        <= '0;
         idx_q        <= '0;
         inv_q        <= 1'b0;
         way_q        <= 1'b0;
         m_q          <= 1'b0;
         s_q          <= 1'b0;
         blk_q        <= 64'd0;
         cctrans_q    <= 1'b0;
         snp_active_q <= 1'b0;
         snp_daddr_q  <= 32'd0;
         snp_dstore_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         idx_q        <= idx_d;
         inv_q        <= inv_d;
         way_q        <= way_d;
         m_q          <= m_d;
         s_q          <= s_d;
         blk_q        <= blk_d;
         cctrans_q    <= cctrans_d;
         snp_active_q <= snp_active_d;
         snp_daddr_q  <= snp_daddr_d;
         snp_dstore_q <= snp_dstore_d;
      end
   end

   // cctrans drops in the same cycle ccwait releases the cache
   assign cctrans    = cctrans_q && !((state_q == S_RESP) && !ccwait);
   assign snp_active = snp_active_q;
   assign snp_daddr  = snp_daddr_q;
   assign snp_dstore = snp_dstore_q;
   // a reset cycle must never commit a frame update
   assign upd_en     = upd_en_c && !RST;

endmodule
